// File: rtl/nn_avalon_pkg.sv
// Shared definitions for the NN accelerator Avalon host master and slave side:
// sequencer states, default window addresses, CSR bit indices, command bundle.
package nn_avalon_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_PIX,
        S_LOAD_WGT,
        S_START,
        S_POLL_RD,
        S_POLL_WAIT,
        S_CLEAR,
        S_RES_RD,
        S_RES_WAIT
    } state_e;

    localparam logic [10:0] PIXEL_BASE_DEF  = 11'h000;
    localparam logic [10:0] WEIGHT_BASE_DEF = 11'h30F;
    localparam logic [10:0] RESULT_BASE_DEF = 11'h61F;
    localparam logic [10:0] CSR_ADDR_DEF    = 11'h62B;
    localparam int          START_BIT_DEF   = 3;
    localparam int          DONE_BIT_DEF    = 4;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [10:0] addr;
        logic [31:0] wdata;
    } cmd_req_t;

endpackage

// File: rtl/nn_avm_cmd.sv
// Single-command Avalon-MM handshake: latches one read or write request and
// holds it on the bus until the slave drops waitrequest.
module nn_avm_cmd
    import nn_avalon_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  cmd_req_t    req_i,
    output logic        accepted_o,
    output logic        pending_o,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic [10:0] avm_address_o,
    output logic        avm_write_o,
    output logic        avm_read_o,
    output logic [31:0] avm_writedata_o,
    output logic [9:0]  avm_burstcount_o,
    output logic        avm_beginbursttransfer_o,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_readdatavalid_i
);

    logic        wr_q, wr_d, rd_q, rd_d;
    logic [10:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    assign pending_o  = wr_q | rd_q;
    assign accepted_o = pending_o & ~avm_waitrequest_i;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accepted_o) begin
            wr_d = 1'b0;
            rd_d = 1'b0;
        end else if (!pending_o && req_i.req) begin
            wr_d    = req_i.we;
            rd_d    = ~req_i.we;
            addr_d  = req_i.addr;
            wdata_d = req_i.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign avm_address_o            = addr_q;
    assign avm_write_o              = wr_q;
    assign avm_read_o               = rd_q;
    assign avm_writedata_o          = wdata_q;
    assign avm_burstcount_o         = 10'd1;
    assign avm_beginbursttransfer_o = 1'b0;
    assign rdata_o                  = avm_readdata_i;
    assign rvalid_o                 = avm_readdatavalid_i;

endmodule

// File: rtl/nn_avalon_host_master.sv
// Job sequencer for the NN accelerator: load pixels/weights, kick CSR start,
// poll done, clear start, read back results. Optional macro: POLL_TIMEOUT_EN.
module nn_avalon_host_master
    import nn_avalon_pkg::*;
#(
    parameter logic [10:0] PIXEL_BASE   = PIXEL_BASE_DEF,
    parameter int          PIXEL_COUNT  = 783,
    parameter logic [10:0] WEIGHT_BASE  = WEIGHT_BASE_DEF,
    parameter int          WEIGHT_COUNT = 784,
    parameter logic [10:0] RESULT_BASE  = RESULT_BASE_DEF,
    parameter int          RESULT_COUNT = 10,
    parameter logic [10:0] CSR_ADDR     = CSR_ADDR_DEF,
    parameter int          START_BIT    = START_BIT_DEF,
    parameter int          DONE_BIT     = DONE_BIT_DEF,
    parameter int          POLL_LIMIT   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic        busy,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [16:0] res_data,
    output logic [3:0]  res_index,
    output logic        res_valid,
    output logic        job_done,
    output logic        job_err,
    output logic [10:0] avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    output logic [9:0]  avm_burstcount,
    output logic        avm_beginbursttransfer,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [16:0] res_data_q, res_data_d;
    logic [3:0]  res_index_q, res_index_d;
    logic        res_valid_q, res_valid_d, job_done_q, job_done_d;
    cmd_req_t    cmd;
    logic        accepted, pending, rvalid;
    logic [31:0] rdata;
    logic        unused_rdata_hi;

    assign unused_rdata_hi = ^rdata[31:17];

`ifdef POLL_TIMEOUT_EN
    logic [15:0] poll_q, poll_d;
    logic        to_q, to_d, job_err_q, job_err_d;
`else
    localparam int unused_poll_limit = POLL_LIMIT;
`endif

    nn_avm_cmd u_cmd (
        .clk(clk), .rst(rst), .req_i(cmd),
        .accepted_o(accepted), .pending_o(pending),
        .rdata_o(rdata), .rvalid_o(rvalid),
        .avm_address_o(avm_address), .avm_write_o(avm_write), .avm_read_o(avm_read),
        .avm_writedata_o(avm_writedata), .avm_burstcount_o(avm_burstcount),
        .avm_beginbursttransfer_o(avm_beginbursttransfer),
        .avm_waitrequest_i(avm_waitrequest), .avm_readdata_i(avm_readdata),
        .avm_readdatavalid_i(avm_readdatavalid)
    );

    assign busy     = (state_q != S_IDLE);
    assign in_ready = (state_q == S_LOAD_PIX || state_q == S_LOAD_WGT) && !pending;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_index_d = res_index_q;
        res_valid_d = 1'b0;
        job_done_d  = 1'b0;
        cmd         = '0;
`ifdef POLL_TIMEOUT_EN
        poll_d      = poll_q;
        to_d        = to_q;
        job_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (go) begin
                state_d = S_LOAD_PIX;
                cnt_d   = '0;
            end
            S_LOAD_PIX, S_LOAD_WGT: begin
                cmd.req   = in_valid && in_ready;
                cmd.we    = 1'b1;
                cmd.addr  = ((state_q == S_LOAD_PIX) ? PIXEL_BASE : WEIGHT_BASE) + cnt_q;
                cmd.wdata = {16'h0, in_data};
                if (accepted) begin
                    cnt_d = cnt_q + 11'd1;
                    if (state_q == S_LOAD_PIX && cnt_q == 11'(PIXEL_COUNT - 1)) begin
                        state_d = S_LOAD_WGT;
                        cnt_d   = '0;
                    end else if (state_q == S_LOAD_WGT && cnt_q == 11'(WEIGHT_COUNT - 1)) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cmd = '{req: !pending, we: 1'b1, addr: CSR_ADDR, wdata: 32'(1) << START_BIT};
                if (accepted) begin
                    state_d = S_POLL_RD;
`ifdef POLL_TIMEOUT_EN
                    poll_d  = '0;
                    to_d    = 1'b0;
`endif
                end
            end
            S_POLL_RD: begin
                cmd = '{req: !pending, we: 1'b0, addr: CSR_ADDR, wdata: 32'h0};
                if (accepted) state_d = S_POLL_WAIT;
            end
            S_POLL_WAIT: if (rvalid) begin
                if (rdata[DONE_BIT]) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_POLL_RD;
`ifdef POLL_TIMEOUT_EN
                    poll_d  = poll_q + 16'd1;
                    if (poll_d == 16'(POLL_LIMIT)) begin
                        to_d    = 1'b1;
                        state_d = S_CLEAR;
                    end
`endif
                end
            end
            S_CLEAR: begin
                cmd = '{req: !pending, we: 1'b1, addr: CSR_ADDR, wdata: 32'h0};
                if (accepted) begin
                    state_d = S_RES_RD;
                    cnt_d   = '0;
`ifdef POLL_TIMEOUT_EN
                    // a timed-out job leaves the accelerator idle but skips result readback
                    if (to_q) begin
                        state_d   = S_IDLE;
                        job_err_d = 1'b1;
                    end
`endif
                end
            end
            S_RES_RD: begin
                cmd = '{req: !pending, we: 1'b0, addr: RESULT_BASE + cnt_q, wdata: 32'h0};
                if (accepted) state_d = S_RES_WAIT;
            end
            S_RES_WAIT: if (rvalid) begin
                res_valid_d = 1'b1;
                res_data_d  = rdata[16:0];
                res_index_d = cnt_q[3:0];
                if (cnt_q == 11'(RESULT_COUNT - 1)) begin
                    job_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 11'd1;
                    state_d = S_RES_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_index_q <= '0;
            res_valid_q <= 1'b0;
            job_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_index_q <= res_index_d;
            res_valid_q <= res_valid_d;
            job_done_q  <= job_done_d;
        end
    end

`ifdef POLL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_q    <= '0;
            to_q      <= 1'b0;
            job_err_q <= 1'b0;
        end else begin
            poll_q    <= poll_d;
            to_q      <= to_d;
            job_err_q <= job_err_d;
        end
    end
    assign job_err = job_err_q;
`else
    assign job_err = 1'b0;
`endif

    assign res_data  = res_data_q;
    assign res_index = res_index_q;
    assign res_valid = res_valid_q;
    assign job_done  = job_done_q;

endmodule

// File: tb/tb_nn_avalon_host_master.sv
// Randomized bench: Avalon slave model with stalls/read latency, transaction
// log compared against the job's expected bus sequence and result stream.
module tb_nn_avalon_host_master;

    localparam int PC = 4, WC = 4, RC = 3, PL = 8;
    localparam logic [10:0] CSR = 11'h62B;

    logic clk = 1'b0, rst, go, in_valid, in_ready, busy;
    logic [15:0] in_data;
    logic [16:0] res_data;
    logic [3:0]  res_index;
    logic        res_valid, job_done, job_err;
    logic [10:0] avm_address;
    logic        avm_write, avm_read, avm_beginbursttransfer;
    logic [31:0] avm_writedata, rdata;
    logic [9:0]  avm_burstcount;
    logic        waitreq, rdv;

    always #5 clk = ~clk;

    nn_avalon_host_master #(.PIXEL_COUNT(PC), .WEIGHT_COUNT(WC), .RESULT_COUNT(RC),
                            .POLL_LIMIT(PL)) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .res_data(res_data), .res_index(res_index), .res_valid(res_valid),
        .job_done(job_done), .job_err(job_err),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_burstcount(avm_burstcount),
        .avm_beginbursttransfer(avm_beginbursttransfer),
        .avm_waitrequest(waitreq), .avm_readdata(rdata), .avm_readdatavalid(rdv)
    );

    typedef struct {
        bit          we;
        logic [10:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$], obs_q[$], cur, prev;
    logic [16:0] exp_res[$], obs_res[$];
    int          obs_idx[$];
    logic [15:0] words[$];
    logic [31:0] rd_val;
    int n_tests = 0, n_fail = 0;
    int wait_n, rd_lat, done_polls, valid_pct, hold, rd_timer, poll_n, res_n, words_idx;
    int done_cnt, err_cnt;
    bit spurious, magic, driving, rd_pend, prev_stall, consume_next;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // slave, input driver and output monitor all act on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            waitreq = 0; rdv = 0; hold = 0; rd_pend = 0; prev_stall = 0;
            consume_next = 0; in_valid = 0;
        end else begin
            if (consume_next) words_idx++;
            if (driving && words_idx < words.size()) begin
                in_valid = (words_idx == 0) || ($urandom_range(99) < valid_pct);
                in_data  = in_valid ? words[words_idx] : 16'($urandom);
            end else begin
                in_valid = 0;
            end
            consume_next = in_valid && in_ready;

            if (res_valid) begin
                obs_res.push_back(res_data);
                obs_idx.push_back(int'(res_index));
            end
            if (job_done) done_cnt++;
            if (job_err) err_cnt++;

            if (avm_read) check("one_outstanding", 32'(rd_pend), 0);
            rdv = 0;
            rdata = $urandom;
            if (rd_pend) begin
                if (rd_timer == 0) begin
                    rdv = 1; rdata = rd_val; rd_pend = 0;
                end else rd_timer--;
            end else if (spurious && avm_write && $urandom_range(3) == 0) begin
                rdv = 1; rdata = 32'h10;
            end

            if (avm_write || avm_read) begin
                cur = '{avm_write, avm_address, avm_write ? avm_writedata : 32'h0};
                if (prev_stall) begin
                    check("stable_we", 32'(cur.we), 32'(prev.we));
                    check("stable_addr", 32'(cur.addr), 32'(prev.addr));
                    check("stable_wdata", cur.data, prev.data);
                end
                if (hold < wait_n) begin
                    waitreq = 1; hold++; prev_stall = 1; prev = cur;
                end else begin
                    waitreq = 0; hold = 0; prev_stall = 0;
                    obs_q.push_back(cur);
                    if (!cur.we) begin
                        if (cur.addr == CSR) begin
                            poll_n++;
                            rd_val = ($urandom & ~32'h10) | ((poll_n >= done_polls) ? 32'h10 : 32'h0);
                        end else begin
                            rd_val = (magic && res_n == 0) ? 32'h0001_ABCD : $urandom;
                            exp_res.push_back(rd_val[16:0]);
                            res_n++;
                        end
                        rd_pend = 1; rd_timer = rd_lat;
                    end
                end
            end else begin
                if (prev_stall) check("cmd_held", 0, 1);
                waitreq = 0; prev_stall = 0; hold = 0;
            end
        end
    end

    task automatic start_job(input int wn, input int rl, input int dp, input int vp,
                             input bit sp, input bit mag, input bit expect_err);
        @(posedge clk);
        wait_n = wn; rd_lat = rl; done_polls = dp; valid_pct = vp; spurious = sp; magic = mag;
        exp_q.delete(); obs_q.delete(); exp_res.delete(); obs_res.delete(); obs_idx.delete();
        words.delete();
        poll_n = 0; res_n = 0; words_idx = 0; done_cnt = 0; err_cnt = 0;
        for (int i = 0; i < PC + WC; i++) words.push_back(16'($urandom));
        for (int i = 0; i < PC; i++) exp_q.push_back('{1, 11'(i), {16'h0, words[i]}});
        for (int i = 0; i < WC; i++) exp_q.push_back('{1, 11'h30F + 11'(i), {16'h0, words[PC+i]}});
        exp_q.push_back('{1, CSR, 32'h8});
        for (int i = 0; i < (expect_err ? PL : dp); i++) exp_q.push_back('{0, CSR, 32'h0});
        exp_q.push_back('{1, CSR, 32'h0});
        if (!expect_err)
            for (int i = 0; i < RC; i++) exp_q.push_back('{0, 11'h61F + 11'(i), 32'h0});
        driving = 1;
        @(negedge clk); go = 1;
        @(negedge clk); go = 0;
        check("lat_no_write_yet", 32'(avm_write), 0);
        @(negedge clk);
        check("lat_first_write", 32'(avm_write), 1);
        check("lat_first_addr", 32'(avm_address), 0);
        check("lat_first_data", avm_writedata, {16'h0, words[0]});
    endtask

    task automatic finish_job(input string name, input bit go_mid, input bit expect_err);
        int cyc = 0;
        while (done_cnt == 0 && err_cnt == 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            go = go_mid && (cyc == 6);
        end
        go = 0;
        check({name, "_completed"}, 32'(cyc < 5000), 1);
        repeat (4) @(negedge clk);
        driving = 0;
        check({name, "_ntxn"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_txn%0d_we", name, i), 32'(obs_q[i].we), 32'(exp_q[i].we));
            check($sformatf("%s_txn%0d_addr", name, i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s_txn%0d_data", name, i), obs_q[i].data, exp_q[i].data);
        end
        check({name, "_nres"}, obs_res.size(), expect_err ? 0 : RC);
        for (int i = 0; i < exp_res.size() && i < obs_res.size(); i++) begin
            check($sformatf("%s_res%0d", name, i), 32'(obs_res[i]), 32'(exp_res[i]));
            check($sformatf("%s_idx%0d", name, i), obs_idx[i], i);
        end
        check({name, "_job_done"}, done_cnt, expect_err ? 0 : 1);
        check({name, "_job_err"}, err_cnt, expect_err ? 1 : 0);
        check({name, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        rst = 1; go = 0; in_valid = 0; in_data = 0; waitreq = 0; rdv = 0; rdata = 0;
        driving = 0; spurious = 0; magic = 0; wait_n = 0; rd_lat = 0; words_idx = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_write", 32'(avm_write), 0);
        check("rst_read", 32'(avm_read), 0);
        check("rst_addr", 32'(avm_address), 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_job_done", 32'(job_done), 0);
        check("rst_job_err", 32'(job_err), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("burstcount", 32'(avm_burstcount), 1);
        check("beginburst", 32'(avm_beginbursttransfer), 0);
        @(negedge clk); rst = 0;

        start_job(0, 0, $urandom_range(1, 3), 100, 0, 0, 0);
        finish_job("basic", 0, 0);
        start_job(0, 4, 2, 40, 0, 1, 0);
        finish_job("gaps", 0, 0);
        check("magic_res", 32'(obs_res.size() > 0 ? obs_res[0] : 17'h0), 32'h1ABCD);
        start_job(3, 1, 3, 70, 1, 0, 0);
        finish_job("stall", 1, 0);

        // reset while a CSR poll read is waiting for data
        start_job(0, 6, 1000, 100, 0, 0, 0);
        for (int c = 0; c < 2000 && poll_n < 2; c++) @(negedge clk);
        check("reached_poll", 32'(poll_n >= 2), 1);
        @(negedge clk);
        rst = 1;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_read", 32'(avm_read), 0);
        check("midrst_write", 32'(avm_write), 0);
        check("midrst_addr", 32'(avm_address), 0);
        check("midrst_res_valid", 32'(res_valid), 0);
        repeat (2) @(negedge clk);
        rst = 0; driving = 0;
        start_job($urandom_range(0, 2), $urandom_range(0, 3), 2, 80, 0, 0, 0);
        finish_job("after_rst", 0, 0);

        for (int j = 0; j < 2; j++) begin
            start_job($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(1, 5),
                      $urandom_range(30, 100), 1, 0, 0);
            finish_job($sformatf("rand%0d", j), 0, 0);
        end
`ifdef POLL_TIMEOUT_EN
        start_job(0, 0, 1000, 100, 0, 0, 1);
        finish_job("timeout", 0, 1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nn_avalon_host_master.md
Name: nn_avalon_host_master

Overview:
Avalon-MM initiator that drives the neural-network accelerator's Avalon slave port and runs one complete inference job per go pulse.
- Streams pixels, then weights, from a valid/ready input into the slave's pixel and weight windows.
- Sets the CSR start bit, polls the CSR done bit, clears start, then reads every result register back out on a result stream.
- Sits between the host-side data mover and the accelerator's bus interface.

Parameters:
PIXEL_BASE, 11'h000, first pixel address
PIXEL_COUNT, 783, pixel words per job
WEIGHT_BASE, 11'h30F, first weight address
WEIGHT_COUNT, 784, weight words per job
RESULT_BASE, 11'h61F, first result address
RESULT_COUNT, 10, result words per job (max 16)
CSR_ADDR, 11'h62B, control/status register address
START_BIT, 3, CSR start bit index
DONE_BIT, 4, CSR done bit index
POLL_LIMIT, 4096, max CSR polls before abort (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
go  in  1  start job; sampled only in IDLE
busy  out  1  high in every state except IDLE
in_data  in  16  pixel/weight word
in_valid  in  1  in_data valid
in_ready  out  1  high while in LOAD_PIX/LOAD_WGT with no write outstanding
res_data  out  17  result value (avm_readdata[16:0])
res_index  out  4  result number 0..RESULT_COUNT-1
res_valid  out  1  one-cycle pulse; no backpressure
job_done  out  1  one-cycle pulse at end of job
job_err  out  1  one-cycle pulse on poll timeout (0 unless feature enabled)
avm_address  out  11  bus address
avm_write  out  1  write request
avm_read  out  1  read request
avm_writedata  out  32  write data; upper bits zero-extended
avm_burstcount  out  10  constant 1
avm_beginbursttransfer  out  1  constant 0
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  slave read data
avm_readdatavalid  in  1  read data qualifier

Behaviour:
- Reset, asynchronous: state IDLE; all counters 0; avm_write, avm_read, res_valid, job_done and job_err all 0; avm_address and avm_writedata 0.
- Bus rule: once avm_write or avm_read is asserted, it holds with stable address and data until a rising edge where avm_waitrequest=0. That edge completes the command.
- Reads are single-outstanding. After read acceptance, the block waits for avm_readdatavalid with no timeout.
- States:
  - IDLE: go=1 -> LOAD_PIX with cnt=0.
  - LOAD_PIX: in_valid&in_ready captures in_data into a write to PIXEL_BASE+cnt, in_ready drops. On acceptance cnt++. Leaving after write PIXEL_COUNT-1 -> LOAD_WGT with cnt=0.
  - LOAD_WGT: same handshake, address WEIGHT_BASE+cnt, WEIGHT_COUNT words, then -> START.
  - START: write CSR_ADDR with data 1<<START_BIT -> POLL_RD.
  - POLL_RD: read CSR_ADDR; on acceptance -> POLL_WAIT.
  - POLL_WAIT: on readdatavalid, readdata[DONE_BIT]=1 -> CLEAR, else -> POLL_RD.
  - CLEAR: write CSR_ADDR with 0 -> RES_RD with cnt=0.
  - RES_RD: read RESULT_BASE+cnt -> RES_WAIT.
  - RES_WAIT: on readdatavalid, res_valid=1, res_data=readdata[16:0], res_index=cnt. If cnt=RESULT_COUNT-1, job_done=1 -> IDLE; else cnt++ -> RES_RD.
- Latency: the earliest write follows go by 2 cycles (LOAD entry, then capture). A zero-wait write completes in 1 cycle.
- go while busy: ignored.
- in_valid low mid-load: bus idles (avm_write=0) and the counter holds.
- Address arithmetic is 11-bit; counters are 11 bits wide. Parameter ranges must not overflow 11'h7FF; the slave windows are not checked.
- Reset mid-job: returns to IDLE immediately and any bus command is dropped. The accelerator CSR is left as-is; the next job's START rewrite recovers it.
- readdatavalid outside the WAIT states: ignored.

Optional Feature:
POLL_TIMEOUT_EN.
- Defined: a poll counter resets on entering POLL_RD from START and increments on each POLL_WAIT not-done result. Reaching POLL_LIMIT -> CLEAR, then IDLE, with a job_err pulse, no result reads and no job_done.
- Undefined: polling is unbounded and job_err is tied 0.

Decomposition:
- Package nn_avalon_pkg holds the state enum, the default address constants (PIXEL_BASE..CSR_ADDR) and the CSR bit indices, shared with the slave-side block.
- One sub-module, nn_avm_cmd, owns the single-command handshake. It takes a req/we/addr/wdata input, drives the avm_* outputs, and returns an accepted pulse plus rdata/rvalid. The sequencer FSM sits above it.

Test Plan:
- PIXEL_COUNT=4, WEIGHT_COUNT=4, RESULT_COUNT=3; zero-wait slave model; done asserted after 5 cycles -> 4 writes to 0..3, 4 writes to 0x30F..0x312, CSR write 0x8, polls until bit4, CSR write 0, reads 0x61F..0x621, res_index 0,1,2, one job_done.
- Slave holds waitrequest for 3 cycles on every command -> address/data/write stable throughout; no duplicated or skipped addresses.
- in_valid toggles 1-0-0-1 during pixel load -> avm_write low during gaps; addresses still contiguous.
- readdatavalid delayed 4 cycles after read acceptance -> no new read issued before data; res_data = readdata[16:0] (readdata=0x1_ABCD -> res_data 0x1ABCD).
- rst asserted during POLL_WAIT -> immediate IDLE, outputs 0; a new go runs a full job correctly.
- With POLL_TIMEOUT_EN, POLL_LIMIT=8 and done never set -> 8 polls, CSR write 0, job_err pulse, no res_valid.
